// File: rtl/vga_timing_core.sv
// VGA raster timing: pixel-rate divider, column/row scan counters, registered syncs.
// Optional game_tick pulse every GAME_DIV frames when GAME_TICK_EN is defined.
module vga_timing_core #(
  parameter int PIX_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 11,
  parameter int GAME_DIV = 2
) (
  input  logic          board_clk,
  input  logic          reset,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          disp_en,
  output logic [CW-1:0] column,
  output logic [CW-1:0] row,
  output logic          frame_start,
  output logic          game_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int HS_B    = H_ACTIVE + H_FP;
  localparam int HS_E    = HS_B + H_SYNC - 1;
  localparam int VS_B    = V_ACTIVE + V_FP;
  localparam int VS_E    = VS_B + V_SYNC - 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(HS_B);
  localparam logic [CW-1:0] HS_END   = CW'(HS_E);
  localparam logic [CW-1:0] VS_BEG   = CW'(VS_B);
  localparam logic [CW-1:0] VS_END   = CW'(VS_E);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);
  // Sync levels decoded from the reset position (last column, last row).
  localparam logic HS_RST = ((H_TOTAL - 1) >= HS_B && (H_TOTAL - 1) <= HS_E) ? HS_ON : !HS_ON;
  localparam logic VS_RST = ((V_TOTAL - 1) >= VS_B && (V_TOTAL - 1) <= VS_E) ? VS_ON : !VS_ON;

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_col, r_row;
  logic          r_pix, r_hs, r_vs, r_de, r_fs;

  logic [DW-1:0] w_div_nxt;
  logic [CW-1:0] w_col_nxt, w_row_nxt;
  logic          w_tick, w_col_wrap, w_frame;

  // Scan position moves on the same edge that raises pix_en, so every
  // registered flag describes the pixel shown alongside it.
  always_comb begin
    w_div_nxt  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    w_tick     = (w_div_nxt == DIV_LAST);
    w_col_wrap = (r_col == H_LAST);
    w_frame    = w_tick && w_col_wrap && (r_row == V_LAST);
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    if (w_tick) begin
      w_col_nxt = w_col_wrap ? '0 : r_col + 1'b1;
      if (w_col_wrap) w_row_nxt = (r_row == V_LAST) ? '0 : r_row + 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_div <= '0;
      r_pix <= 1'b0;
      r_col <= H_LAST;
      r_row <= V_LAST;
      r_hs  <= HS_RST;
      r_vs  <= VS_RST;
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      r_pix <= w_tick;
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_hs  <= (w_col_nxt >= HS_BEG && w_col_nxt <= HS_END) ? HS_ON : !HS_ON;
      r_vs  <= (w_row_nxt >= VS_BEG && w_row_nxt <= VS_END) ? VS_ON : !VS_ON;
      r_de  <= (w_col_nxt < H_ACT) && (w_row_nxt < V_ACT);
      r_fs  <= w_frame;
    end
  end

  assign pix_en      = r_pix;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign disp_en     = r_de;
  assign column      = r_col;
  assign row         = r_row;
  assign frame_start = r_fs;

`ifdef GAME_TICK_EN
  localparam int            GW        = (GAME_DIV > 1) ? $clog2(GAME_DIV) : 1;
  localparam logic [GW-1:0] GAME_LAST = GW'(GAME_DIV - 1);

  logic [GW-1:0] r_frm;
  logic          r_gt;

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_frm <= '0;
      r_gt  <= 1'b0;
    end else begin
      r_gt <= w_frame && (r_frm == '0);
      if (w_frame) r_frm <= (r_frm == GAME_LAST) ? '0 : r_frm + 1'b1;
    end
  end

  assign game_tick = r_gt;
`else
  // GAME_DIV only matters when the tick is built.
  assign game_tick = (GAME_DIV >= 1) ? 1'b0 : 1'b0;
`endif

endmodule
